// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// register bit positions and serializer states.
package uart_pkg;

  // Byte offsets within the 16-byte register window (a[3:2] selects the word).
  localparam logic [3:0] TXDATA_OFF = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] CTRL_OFF   = 4'h8;
  localparam logic [3:0] RSVD_OFF   = 4'hC;

  // STATUS bit positions; the FIFO count field starts at STATUS_COUNT_LSB.
  localparam int unsigned STATUS_FULL      = 0;
  localparam int unsigned STATUS_EMPTY     = 1;
  localparam int unsigned STATUS_BUSY      = 2;
  localparam int unsigned STATUS_OVF       = 3;
  localparam int unsigned STATUS_COUNT_LSB = 4;

  // CTRL bit positions.
  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_CLR_OVF = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy count.
// A push into a full FIFO is still accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtrQ, rdPtrQ;
  logic [CW-1:0]    countQ;
  logic             doPush, doPop;

  // Qualify requests against occupancy.
  always_comb begin
    doPop  = pop & (countQ != '0);
    doPush = push & ((countQ < CW'(DEPTH)) | doPop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtrQ <= wrPtrQ + PW'(1);
      if (doPop)  rdPtrQ <= rdPtrQ + PW'(1);
      if (doPush && !doPop)      countQ <= countQ + CW'(1);
      else if (doPop && !doPush) countQ <= countQ - CW'(1);
    end
  end

  // Storage needs no reset; only entries behind the pointers are ever read.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtrQ] <= wdata;
  end

  // Head-of-queue and status outputs.
  always_comb begin
    rdata = mem[rdPtrQ];
    full  = (countQ == CW'(DEPTH));
    empty = (countQ == '0);
    count = countQ;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the core's data-memory bus.
// Stores to TXDATA queue bytes; a serializer FSM drains the queue onto tx.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(CLK_DIV);

  logic          hit, pushReq, ctrlWr, pop, ovfSet, baudEnd;
  logic [3:0]    off;
  logic          fifoFull, fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic [7:0]    fifoHead;

  txState_e      stateQ, stateD;
  logic [BW-1:0] baudQ, baudD;
  logic [2:0]    bitIdxQ, bitIdxD;
  logic [7:0]    shiftQ, shiftD;
  logic          enableQ, ovfQ;

  // Byte-lane bits of the address and upper store data have no meaning here.
  logic unusedBits;
  assign unusedBits = ^{a[1:0], wd[31:8]};

  // Address decode and write strobes.
  always_comb begin
    hit     = (a[31:4] == BASE_ADDR[31:4]);
    off     = {a[3:2], 2'b00};
    pushReq = we & hit & (off == TXDATA_OFF);
    ctrlWr  = we & hit & (off == CTRL_OFF);
    // A push to a full FIFO survives only if the serializer pops on the same edge.
    ovfSet  = pushReq & fifoFull & ~pop;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pushReq),
    .wdata (wd[7:0]),
    .pop   (pop),
    .rdata (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // Serializer next-state, pop request and line output.
  always_comb begin
    stateD  = stateQ;
    baudD   = baudQ + BW'(1);
    bitIdxD = bitIdxQ;
    shiftD  = shiftQ;
    pop     = 1'b0;
    tx      = 1'b1;
    baudEnd = (baudQ == BW'(CLK_DIV - 1));
    unique case (stateQ)
      IDLE: begin
        baudD = '0;
        if (enableQ && !fifoEmpty) begin
          pop    = 1'b1;
          shiftD = fifoHead;
          stateD = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (baudEnd) begin
          baudD   = '0;
          bitIdxD = '0;
          stateD  = DATA;
        end
      end
      DATA: begin
        tx = shiftQ[0];
        if (baudEnd) begin
          baudD   = '0;
          shiftD  = shiftQ >> 1;
          bitIdxD = bitIdxQ + 3'd1;
          if (bitIdxQ == 3'd7) stateD = STOP;
        end
      end
      STOP: begin
        if (baudEnd) begin
          baudD = '0;
          // Chain straight into the next frame when more data is queued.
          if (enableQ && !fifoEmpty) begin
            pop    = 1'b1;
            shiftD = fifoHead;
            stateD = START;
          end else begin
            stateD = IDLE;
          end
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Serializer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ  <= IDLE;
      baudQ   <= '0;
      bitIdxQ <= '0;
      shiftQ  <= '0;
    end else begin
      stateQ  <= stateD;
      baudQ   <= baudD;
      bitIdxQ <= bitIdxD;
      shiftQ  <= shiftD;
    end
  end

  // Control register and sticky overflow flag; a new overflow beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enableQ <= 1'b1;
      ovfQ    <= 1'b0;
    end else begin
      if (ctrlWr) enableQ <= wd[CTRL_ENABLE];
      if (ovfSet) ovfQ <= 1'b1;
      else if (ctrlWr && wd[CTRL_CLR_OVF]) ovfQ <= 1'b0;
    end
  end

  // Load data mux and busy indication.
  always_comb begin
    busy = (stateQ != IDLE) | ~fifoEmpty;
    rd   = '0;
    if (hit) begin
      case (off)
        STATUS_OFF: begin
          rd[STATUS_FULL]                 = fifoFull;
          rd[STATUS_EMPTY]                = fifoEmpty;
          rd[STATUS_BUSY]                 = busy;
          rd[STATUS_OVF]                  = ovfQ;
          rd[STATUS_COUNT_LSB +: CW]      = fifoCount;
        end
        CTRL_OFF: rd[CTRL_ENABLE] = enableQ;
        default:  rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLK_DIV=4 and a 4-entry FIFO.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst, we;
  logic [31:0] a, wd, rd, rv;
  logic        tx, busy;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .a    (a),
    .wd   (wd),
    .rd   (rd),
    .tx   (tx),
    .busy (busy)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One-cycle store; returns at the falling edge after the capturing edge.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    a  = addr;
    wd = data;
    @(negedge clk);
    we = 1'b0;
    a  = '0;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
    a = addr;
    #1;
    data = rd;
    a = '0;
  endtask

  // Expected line level at cycle pos (0..39) of a frame carrying b.
  function automatic logic frameBit(input logic [7:0] b, input int pos);
    int bitNo;
    bitNo = pos / 4;
    if (bitNo == 0) return 1'b0;
    if (bitNo == 9) return 1'b1;
    return b[bitNo-1];
  endfunction

  initial begin
    rst = 1'b0;
    we  = 1'b0;
    a   = '0;
    wd  = '0;
    repeat (2) @(negedge clk);
    checkEq("rstTx", 32'(tx), 32'd1);
    checkEq("rstBusy", 32'(busy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    readReg(BASE + 32'h4, rv);
    checkEq("rstStatus", rv, 32'h2);
    readReg(BASE + 32'h8, rv);
    checkEq("rstCtrl", rv, 32'h1);
    checkEq("idleTx", 32'(tx), 32'd1);

    // Single frame: start bit appears one edge after the store.
    store(BASE, 32'hA5);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      checkEq($sformatf("frameA5[%0d]", i), 32'(tx), 32'(frameBit(8'hA5, i)));
      if (i == 20) checkEq("busyMidFrame", 32'(busy), 32'd1);
      @(negedge clk);
    end
    checkEq("busyAfterA5", 32'(busy), 32'd0);

    // Three back-to-back stores give three contiguous frames.
    @(negedge clk);
    we = 1'b1;
    a  = BASE;
    wd = 32'h01;
    @(negedge clk);
    wd = 32'h02;
    @(negedge clk);
    wd = 32'h03;
    @(negedge clk);
    we = 1'b0;
    a  = '0;
    readReg(BASE + 32'h4, rv);
    checkEq("statusCount2", rv, 32'h24);
    for (int i = 1; i < 120; i++) begin
      checkEq($sformatf("b2b[%0d]", i), 32'(tx), 32'(frameBit(8'(i / 40 + 1), i % 40)));
      @(negedge clk);
    end
    checkEq("busyAfterB2b", 32'(busy), 32'd0);
    readReg(BASE + 32'h4, rv);
    checkEq("statusAfterB2b", rv, 32'h2);

    // Overflow with transmission disabled; busy is set since the FIFO holds data.
    store(BASE + 32'h8, 32'h0);
    for (int j = 0; j < 5; j++) store(BASE, 32'h10 + 32'(j));
    readReg(BASE + 32'h4, rv);
    checkEq("statusOvf", rv, 32'h4D);
    readReg(BASE + 32'h8, rv);
    checkEq("ctrlDisabled", rv, 32'h0);
    checkEq("disabledTx", 32'(tx), 32'd1);
    store(BASE + 32'h8, 32'h3);
    readReg(BASE + 32'h4, rv);
    checkEq("statusOvfClr", rv, 32'h45);
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      checkEq($sformatf("frame10[%0d]", i), 32'(tx), 32'(frameBit(8'h10, i)));
      @(negedge clk);
    end
    begin
      int n = 0;
      while (busy && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    checkEq("drainDone", 32'(busy), 32'd0);
    readReg(BASE + 32'h4, rv);
    checkEq("statusDrained", rv, 32'h2);

    // Reset in the middle of data bit 3.
    store(BASE, 32'hA5);
    @(negedge clk);
    repeat (17) @(negedge clk);
    checkEq("bit3Low", 32'(tx), 32'd0);
    checkEq("bit3Busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkEq("asyncRstTx", 32'(tx), 32'd1);
    checkEq("asyncRstBusy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    readReg(BASE + 32'h4, rv);
    checkEq("statusAfterRst", rv, 32'h2);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      checkEq($sformatf("noResidual[%0d]", i), 32'(tx), 32'd1);
    end

    // Stores outside the window are ignored; reads there return zero.
    store(BASE + 32'h10, 32'h55);
    store(32'h0, 32'h55);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkEq($sformatf("missTx[%0d]", i), 32'(tx), 32'd1);
    end
    checkEq("missBusy", 32'(busy), 32'd0);
    readReg(BASE + 32'h10, rv);
    checkEq("readAbove", rv, 32'h0);
    readReg(32'h0, rv);
    checkEq("readZero", rv, 32'h0);
    readReg(BASE + 32'hC, rv);
    checkEq("readRsvd", rv, 32'h0);
    readReg(BASE, rv);
    checkEq("readTxdata", rv, 32'h0);
    readReg(BASE + 32'h4, rv);
    checkEq("statusAfterMiss", rv, 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
